// File: rtl/vram_burst_reader.sv
// vram_burst_reader: turns a (start address, word count) command into a series
// of strobe/ack reads on one VRAM arbiter port. Returned words are buffered in a
// small FIFO that a renderer drains over valid/ready.
module vram_burst_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] start_addr,
  input  logic [8:0]  word_count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [14:0] bus_addr,
  output logic        bus_strobe,
  input  logic [31:0] bus_rddata,
  input  logic        bus_ack,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             strobe_q, strobe_d;
  logic [14:0]      addr_q, addr_d;
  logic [8:0]       left_q, left_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      fifo_mem_q [FIFO_DEPTH];

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_step;
  logic [8:0]       left_step;

  // An ack only counts while a request is actually outstanding in FETCH;
  // acks in IDLE/DRAIN or in an aborting cycle are stale and dropped.
  assign push       = (state_q == ST_FETCH) && strobe_q && bus_ack && !abort;
  assign pop        = (count_q != '0) && out_ready;
  assign count_step = count_q + CNT_W'(push) - CNT_W'(pop);
  assign left_step  = left_q - 9'(push);

  assign busy       = busy_q;
  assign done       = done_q;
  assign bus_addr   = addr_q;
  assign bus_strobe = strobe_q;
  assign out_valid  = (count_q != '0);
  assign out_data   = (count_q != '0) ? fifo_mem_q[rd_ptr_q] : '0;

  // Next-state logic for the burst sequencer, request port and FIFO pointers.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    strobe_d = strobe_q;
    addr_d   = addr_q;
    left_d   = left_q;
    count_d  = count_step;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    if (abort) begin
      state_d  = ST_IDLE;
      busy_d   = 1'b0;
      strobe_d = 1'b0;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              state_d  = ST_FETCH;
              busy_d   = 1'b1;
              strobe_d = 1'b1;
              addr_d   = start_addr;
              left_d   = word_count;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (push) begin
            addr_d = addr_q + 15'd1;
          end
          left_d = left_step;
          if (left_step == '0) begin
            state_d  = ST_DRAIN;
            strobe_d = 1'b0;
          end else begin
            // Request only when the returned word is sure to have a slot;
            // an unanswered request is held regardless.
            strobe_d = (strobe_q && !push) || (count_step < DEPTH_C);
          end
        end
        ST_DRAIN: begin
          if (count_step == '0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          busy_d   = 1'b0;
          strobe_d = 1'b0;
        end
      endcase
    end
  end

  // Control state and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      left_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= bus_rddata;
    end
  end

  // The request reservation must make a push into a full FIFO unreachable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && (count_q == DEPTH_C)))
        else $error("vram_burst_reader: push into full FIFO");
    end
  end

endmodule

// File: tb/tb_vram_burst_reader.sv
// Directed bench for vram_burst_reader: an arbiter model granting every 4th
// cycle (ack one cycle after the grant), a transaction-level reference model
// checked every cycle, and literal expectations for each scenario.
module tb_vram_burst_reader;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [14:0] start_addr = '0;
  logic [8:0]  word_count = '0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] bus_rddata = '0;
  logic        bus_ack = 1'b0;
  logic        busy, done, bus_strobe, out_valid;
  logic [14:0] bus_addr;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  vram_burst_reader #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus_addr   (bus_addr),
    .bus_strobe (bus_strobe),
    .bus_rddata (bus_rddata),
    .bus_ack    (bus_ack),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_busy = 1'b0;
  logic        m_strobe = 1'b0;
  logic        m_done = 1'b0;
  logic [14:0] m_addr = '0;
  int          m_left = 0;
  logic [31:0] m_q[$];

  // observation logs for the literal checks
  logic [31:0] popped[$];
  logic [14:0] acked[$];
  int          done_cnt = 0;

  // arbiter model
  logic [15:0] tag = '0;
  int unsigned cyc = 0;
  logic        pend = 1'b0;
  logic [31:0] g_data = '0;
  logic        grant_now = 1'b0;
  int          grant_cnt = 0;

  function automatic logic [31:0] data_of(input logic [15:0] t, input logic [14:0] a);
    return {t, 1'b0, a};
  endfunction

  // grant on every 4th cycle while a request is up; ack the following cycle
  always @(posedge clk) begin
    #1;
    cyc++;
    grant_now = 1'b0;
    bus_ack = 1'b0;
    if (reset) begin
      pend = 1'b0;
    end else if (pend) begin
      bus_ack = 1'b1;
      bus_rddata = g_data;
      pend = 1'b0;
    end else if (bus_strobe && (cyc % 4 == 0)) begin
      pend = 1'b1;
      g_data = data_of(tag, bus_addr);
      grant_now = 1'b1;
      grant_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare DUT against the model, then advance the model by this cycle's inputs
  task automatic step_model();
    logic p_pop, p_push;
    if (reset) begin
      m_busy = 1'b0; m_strobe = 1'b0; m_done = 1'b0; m_addr = '0; m_left = 0;
      m_q.delete();
      return;
    end
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("bus_strobe", 32'(bus_strobe), 32'(m_strobe));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_strobe) chk("bus_addr", 32'(bus_addr), 32'(m_addr));
    if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
    if (done) done_cnt++;
    if (m_busy && m_strobe && bus_ack) acked.push_back(bus_addr);
    if (out_valid && out_ready) popped.push_back(out_data);

    m_done = 1'b0;
    if (abort) begin
      m_busy = 1'b0; m_strobe = 1'b0; m_left = 0;
      m_q.delete();
    end else if (!m_busy) begin
      if (start) begin
        if (word_count == 9'd0) begin
          m_done = 1'b1;
        end else begin
          m_busy = 1'b1; m_strobe = 1'b1; m_addr = start_addr; m_left = int'(word_count);
        end
      end
    end else begin
      p_pop  = (m_q.size() != 0) && out_ready;
      p_push = bus_ack && m_strobe;
      if (p_pop) void'(m_q.pop_front());
      if (p_push) begin
        m_q.push_back(bus_rddata);
        m_left--;
        m_addr = m_addr + 15'd1;
      end
      m_strobe = (m_left > 0) && (m_q.size() < DEPTH);
      if (m_left == 0 && m_q.size() == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step_model();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input logic [14:0] a, input logic [8:0] n, input logic [15:0] t);
    tag = t;
    popped.delete();
    acked.delete();
    start_addr = a;
    word_count = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int k;
    d0 = done_cnt;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      k++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int d_before;
    int g0;
    logic found;

    // reset state
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(bus_strobe), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1: basic burst
    out_ready = 1'b1;
    d_before = done_cnt;
    run_burst(15'h0010, 9'd4, 16'h0000);
    wait_done(100, "t1_done");
    tick();
    chk("t1_npop", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) chk("t1_data", popped[i], 32'h10 + 32'(i));
    chk("t1_done_cnt", 32'(done_cnt - d_before), 32'd1);
    chk("t1_strobe_off", 32'(bus_strobe), 32'd0);

    // 2: backpressure
    out_ready = 1'b0;
    run_burst(15'h0100, 9'd10, 16'h0001);
    repeat (60) tick();
    chk("t2_acks_full", 32'(acked.size()), 32'd4);
    chk("t2_strobe_full", 32'(bus_strobe), 32'd0);
    chk("t2_valid_full", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_done(200, "t2_done");
    chk("t2_npop", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < popped.size()) chk("t2_data", popped[i], 32'h0001_0100 + 32'(i));

    // 3: address wrap
    run_burst(15'h7FFE, 9'd3, 16'h0002);
    wait_done(100, "t3_done");
    chk("t3_nack", 32'(acked.size()), 32'd3);
    if (acked.size() == 3) begin
      chk("t3_addr0", 32'(acked[0]), 32'h7FFE);
      chk("t3_addr1", 32'(acked[1]), 32'h7FFF);
      chk("t3_addr2", 32'(acked[2]), 32'h0000);
    end
    if (popped.size() == 3) chk("t3_data2", popped[2], 32'h0002_0000);

    // 4: abort in the cycle of the 2nd grant, restart next cycle
    d_before = done_cnt;
    g0 = grant_cnt;
    run_burst(15'h0200, 9'd5, 16'h0003);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      #1;
      if (grant_now && grant_cnt == g0 + 2) found = 1'b1;
    end
    chk("t4_grant2_seen", 32'(found), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy_abort", 32'(busy), 32'd0);
    chk("t4_valid_abort", 32'(out_valid), 32'd0);
    chk("t4_strobe_abort", 32'(bus_strobe), 32'd0);
    chk("t4_no_done", 32'(done_cnt - d_before), 32'd0);
    run_burst(15'h0300, 9'd2, 16'h0004);
    wait_done(100, "t4_done");
    chk("t4_npop", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      chk("t4_data0", popped[0], 32'h0004_0300);
      chk("t4_data1", popped[1], 32'h0004_0301);
    end

    // 5: zero count, then start while busy
    start_addr = 15'h0444;
    word_count = 9'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_zero_done", 32'(done), 32'd1);
    chk("t5_zero_busy", 32'(busy), 32'd0);
    chk("t5_zero_strobe", 32'(bus_strobe), 32'd0);
    tick();
    chk("t5_zero_done_pulse", 32'(done), 32'd0);
    run_burst(15'h0400, 9'd3, 16'h0005);
    repeat (3) tick();
    start_addr = 15'h0500;
    word_count = 9'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100, "t5_done");
    chk("t5_nack", 32'(acked.size()), 32'd3);
    chk("t5_npop", 32'(popped.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < popped.size()) chk("t5_data", popped[i], 32'h0005_0400 + 32'(i));

    // 6: asynchronous reset mid-burst
    out_ready = 1'b0;
    run_burst(15'h0600, 9'd6, 16'h0006);
    repeat (12) tick();
    chk("t6_valid_before", 32'(out_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_strobe", 32'(bus_strobe), 32'd0);
    chk("t6_addr", 32'(bus_addr), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_data", out_data, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    run_burst(15'h0010, 9'd2, 16'h0007);
    wait_done(100, "t6_done");
    chk("t6_npop", 32'(popped.size()), 32'd2);
    if (popped.size() == 2) begin
      chk("t6_data0", popped[0], 32'h0007_0010);
      chk("t6_data1", popped[1], 32'h0007_0011);
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
